// File: rtl/ptp_rx_event_extract.sv
// Receive-side PTP event extractor: pairs each MAC frame with its timestamp and emits {msgType, sequenceId, ts}.
// Optional 802.1Q single-tag parsing is enabled by defining PTP_RX_VLAN_EN.
module ptp_rx_event_extract #(
    parameter int          PTP_TS_WIDTH  = 96,
    parameter logic [15:0] ETHERTYPE     = 16'h88F7,
    parameter logic [15:0] MSG_TYPE_MASK = 16'h000F
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic [PTP_TS_WIDTH-1:0] s_axis_ts_96,
    input  logic                    s_axis_ts_valid,
    output logic                    s_axis_ts_ready,
    output logic [PTP_TS_WIDTH-1:0] m_axis_evt_ts_96,
    output logic [3:0]              m_axis_evt_msg_type,
    output logic [15:0]             m_axis_evt_seq_id,
    output logic                    m_axis_evt_valid,
    input  logic                    m_axis_evt_ready,
    output logic                    stat_match,
    output logic                    stat_reject
);

    typedef enum logic {RUN, TS} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        qualify;
    logic        byte_hs, last_hs, ts_hs, qual_now;

    logic [15:0] f_type0;
    logic [3:0]  f_msg0, f_ver0;
    logic [15:0] f_seq0;
`ifdef PTP_RX_VLAN_EN
    logic [15:0] f_type1;
    logic [3:0]  f_msg1, f_ver1;
    logic [15:0] f_seq1;
`endif

    logic [15:0] eth_sel;
    logic [3:0]  msg_sel, ver_sel;
    logic [15:0] seq_sel;
    logic        len_ok;

    assign byte_hs = s_axis_tvalid && s_axis_tready;
    assign last_hs = byte_hs && s_axis_tlast;
    assign ts_hs   = s_axis_ts_valid && s_axis_ts_ready;

    // Both tagged and untagged field slots are captured; the tag decides which set is used.
    always_comb begin
        eth_sel = f_type0;
        msg_sel = f_msg0;
        ver_sel = f_ver0;
        seq_sel = f_seq0;
        len_ok  = (cnt >= 6'd45);
`ifdef PTP_RX_VLAN_EN
        if (f_type0 == 16'h8100) begin
            eth_sel = f_type1;
            msg_sel = f_msg1;
            ver_sel = f_ver1;
            seq_sel = f_seq1;
            len_ok  = (cnt >= 6'd49);
        end
`endif
        qual_now = (eth_sel == ETHERTYPE) && (ver_sel == 4'd2) && MSG_TYPE_MASK[msg_sel]
                   && len_ok && !s_axis_tuser;
    end

    always_comb begin
        state_nxt       = state;
        s_axis_ts_ready = 1'b0;
        case (state)
            RUN: if (last_hs) state_nxt = TS;
            TS: begin
                s_axis_ts_ready = !qualify || !m_axis_evt_valid || m_axis_evt_ready;
                if (s_axis_ts_valid && s_axis_ts_ready) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= RUN;
            cnt              <= 6'd0;
            qualify          <= 1'b0;
            s_axis_tready    <= 1'b0;
            m_axis_evt_valid <= 1'b0;
            stat_match       <= 1'b0;
            stat_reject      <= 1'b0;
        end else begin
            state         <= state_nxt;
            s_axis_tready <= (state_nxt == RUN);
            stat_match    <= ts_hs && qualify;
            stat_reject   <= ts_hs && !qualify;
            if (last_hs) begin
                cnt     <= 6'd0;
                qualify <= qual_now;
            end else if (byte_hs && cnt != 6'd63) begin
                cnt <= cnt + 6'd1;
            end
            // A load in the same cycle as a drain keeps the entry occupied.
            if (ts_hs && qualify)
                m_axis_evt_valid <= 1'b1;
            else if (m_axis_evt_ready)
                m_axis_evt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_hs) begin
            case (cnt)
                6'd12: f_type0[15:8] <= s_axis_tdata;
                6'd13: f_type0[7:0]  <= s_axis_tdata;
                6'd14: f_msg0        <= s_axis_tdata[3:0];
                6'd15: f_ver0        <= s_axis_tdata[3:0];
                6'd44: f_seq0[15:8]  <= s_axis_tdata;
                6'd45: f_seq0[7:0]   <= s_axis_tdata;
`ifdef PTP_RX_VLAN_EN
                6'd16: f_type1[15:8] <= s_axis_tdata;
                6'd17: f_type1[7:0]  <= s_axis_tdata;
                6'd18: f_msg1        <= s_axis_tdata[3:0];
                6'd19: f_ver1        <= s_axis_tdata[3:0];
                6'd48: f_seq1[15:8]  <= s_axis_tdata;
                6'd49: f_seq1[7:0]   <= s_axis_tdata;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ts_hs && qualify) begin
            m_axis_evt_ts_96    <= s_axis_ts_96;
            m_axis_evt_msg_type <= msg_sel;
            m_axis_evt_seq_id   <= seq_sel;
        end
    end

endmodule

// File: tb/tb_ptp_rx_event_extract.sv
// Scoreboard bench for ptp_rx_event_extract: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_ptp_rx_event_extract;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [3:0]  msg;
        logic [15:0] seq;
        logic [95:0] ts;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [95:0] s_axis_ts_96 = 96'd0;
    logic        s_axis_ts_valid = 1'b0;
    logic        s_axis_ts_ready;
    logic [95:0] m_axis_evt_ts_96;
    logic [3:0]  m_axis_evt_msg_type;
    logic [15:0] m_axis_evt_seq_id;
    logic        m_axis_evt_valid;
    logic        m_axis_evt_ready = 1'b0;
    logic        stat_match, stat_reject;

    int   n_vec = 0, n_err = 0;
    int   exp_match = 0, exp_reject = 0, obs_match = 0, obs_reject = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit   gap_en = 1'b0;
    rec_t exp_q[$];
    logic [95:0] ts_q[$];
    rec_t mon_e;
    int   ts_to;

    ptp_rx_event_extract dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_ts_96(s_axis_ts_96), .s_axis_ts_valid(s_axis_ts_valid), .s_axis_ts_ready(s_axis_ts_ready),
        .m_axis_evt_ts_96(m_axis_evt_ts_96), .m_axis_evt_msg_type(m_axis_evt_msg_type),
        .m_axis_evt_seq_id(m_axis_evt_seq_id), .m_axis_evt_valid(m_axis_evt_valid),
        .m_axis_evt_ready(m_axis_evt_ready),
        .stat_match(stat_match), .stat_reject(stat_reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Frame-level reference: decide qualification straight from the byte list.
    function automatic bit model_qual(input bq_t f, input bit tuser,
                                      output logic [3:0] msg, output logic [15:0] seq);
        int          o;
        logic [15:0] eth;
        logic [7:0]  b;
        logic [3:0]  ver;
        logic [15:0] mask;
        mask = 16'h000F;
        o = 0; msg = 4'd0; seq = 16'd0;
        if (f.size() >= 14 && f[12] == 8'h81 && f[13] == 8'h00) begin
`ifdef PTP_RX_VLAN_EN
            o = 4;
`else
            return 1'b0;
`endif
        end
        if (f.size() < 46 + o || tuser) return 1'b0;
        eth = {f[12+o], f[13+o]};
        b = f[14+o]; msg = b[3:0];
        b = f[15+o]; ver = b[3:0];
        seq = {f[44+o], f[45+o]};
        return (eth == 16'h88F7) && (ver == 4'd2) && mask[msg];
    endfunction

    task automatic build(output bq_t f, input int len, input bit tag, input logic [15:0] eth,
                         input logic [7:0] b14, input logic [7:0] b15, input logic [15:0] seq);
        int o;
        o = tag ? 4 : 0;
        f = {};
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        if (tag) begin f[12] = 8'h81; f[13] = 8'h00; end
        if (12 + o < len) f[12+o] = eth[15:8];
        if (13 + o < len) f[13+o] = eth[7:0];
        if (14 + o < len) f[14+o] = b14;
        if (15 + o < len) f[15+o] = b15;
        if (44 + o < len) f[44+o] = seq[15:8];
        if (45 + o < len) f[45+o] = seq[7:0];
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
    task automatic drive_byte(input logic [7:0] d, input bit last, input bit user);
        int to;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user; s_axis_tvalid = 1'b1;
        to = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready || to > 2000) break;
            to++;
            @(posedge clk); #1;
        end
        if (to > 2000) chk("byte_accept_timeout", 128'(1), 128'(0));
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input bit tuser, input logic [95:0] ts, input bit push_ts);
        logic [3:0]  m;
        logic [15:0] s;
        rec_t        r;
        if (model_qual(f, tuser, m, s)) begin
            r.msg = m; r.seq = s; r.ts = ts;
            exp_q.push_back(r);
            exp_match++;
        end else begin
            exp_reject++;
        end
        if (push_ts) ts_q.push_back(ts);
        for (int i = 0; i < f.size(); i++) drive_byte(f[i], i == f.size() - 1, tuser);
    endtask

    task automatic wait_drain();
        int to;
        to = 0;
        while ((ts_q.size() != 0 || s_axis_ts_valid || exp_q.size() != 0 || m_axis_evt_valid) && to < 4000) begin
            @(posedge clk); #1;
            to++;
        end
        chk("drain_timeout", 128'(to >= 4000), 128'(0));
    endtask

    // Timestamp source: one timestamp per frame, held until consumed.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ts_q.size() != 0) begin
                s_axis_ts_96 = ts_q.pop_front();
                s_axis_ts_valid = 1'b1;
                ts_to = 0;
                forever begin
                    @(negedge clk);
                    if (s_axis_ts_ready || ts_to > 3000) break;
                    ts_to++;
                    @(posedge clk); #1;
                end
                if (ts_to > 3000) chk("ts_accept_timeout", 128'(1), 128'(0));
                @(posedge clk); #1;
                s_axis_ts_valid = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       m_axis_evt_ready = 1'($urandom_range(0, 1));
            1:       m_axis_evt_ready = 1'b1;
            default: m_axis_evt_ready = 1'b0;
        endcase
    end

    // Monitor: every accepted record must match the head of the scoreboard.
    always @(negedge clk) begin
        if (stat_match) obs_match++;
        if (stat_reject) obs_reject++;
        if (rst_n && m_axis_evt_valid && m_axis_evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec_msg_type", 128'(m_axis_evt_msg_type), 128'(mon_e.msg));
                chk("rec_seq_id", 128'(m_axis_evt_seq_id), 128'(mon_e.seq));
                chk("rec_ts", 128'(m_axis_evt_ts_96), 128'(mon_e.ts));
            end
        end
    end

    initial begin
        #700000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        bq_t         f;
        int          m0, r0, kind, len;
        bit          tag, tuser;
        logic [15:0] eth, seq;
        logic [7:0]  b14, b15;
        logic [95:0] ts;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tready", 128'(s_axis_tready), 128'(0));
        chk("rst_ts_ready", 128'(s_axis_ts_ready), 128'(0));
        chk("rst_evt_valid", 128'(m_axis_evt_valid), 128'(0));
        chk("rst_stat_match", 128'(stat_match), 128'(0));
        chk("rst_stat_reject", 128'(stat_reject), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_reset", 128'(s_axis_tready), 128'(1));

        // Sync accepted, with frame-end timing
        ts = 96'h1_00000000_0000_3B9A_C9FF;
        build(f, 64, 1'b0, 16'h88F7, 8'h00, 8'h02, 16'h1234);
        send_frame(f, 1'b0, ts, 1'b1);
        @(negedge clk);
        chk("ts_cycle_tready", 128'(s_axis_tready), 128'(0));
        chk("ts_cycle_ts_ready", 128'(s_axis_ts_ready), 128'(1));
        @(posedge clk); #1;
        chk("n2_evt_valid", 128'(m_axis_evt_valid), 128'(1));
        chk("n2_stat_match", 128'(stat_match), 128'(1));
        chk("n2_tready", 128'(s_axis_tready), 128'(1));
        chk("sync_seq", 128'(m_axis_evt_seq_id), 128'(16'h1234));
        chk("sync_ts", 128'(m_axis_evt_ts_96), 128'(ts));
        wait_drain();

        // Rejects still consume timestamps
        m0 = obs_match; r0 = obs_reject;
        build(f, 64, 1'b0, 16'h0800, 8'h00, 8'h02, 16'h0001); send_frame(f, 1'b0, 96'hA1, 1'b1);
        build(f, 64, 1'b0, 16'h88F7, 8'h0B, 8'h02, 16'h0002); send_frame(f, 1'b0, 96'hA2, 1'b1);
        build(f, 64, 1'b0, 16'h88F7, 8'h00, 8'h01, 16'h0003); send_frame(f, 1'b0, 96'hA3, 1'b1);
        build(f, 64, 1'b0, 16'h88F7, 8'h00, 8'h02, 16'h0004); send_frame(f, 1'b1, 96'hA4, 1'b1);
        build(f, 40, 1'b0, 16'h88F7, 8'h00, 8'h02, 16'h0005); send_frame(f, 1'b0, 96'hA5, 1'b1);
        wait_drain();
        chk("reject_pulses", 128'(obs_reject - r0), 128'(5));
        chk("reject_no_match", 128'(obs_match - m0), 128'(0));

        // Output backpressure
        rdy_mode = 2;
        build(f, 60, 1'b0, 16'h88F7, 8'h01, 8'h02, 16'h0001); send_frame(f, 1'b0, 96'hB1, 1'b1);
        build(f, 60, 1'b0, 16'h88F7, 8'h03, 8'h02, 16'h0002); send_frame(f, 1'b0, 96'hB2, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_tready", 128'(s_axis_tready), 128'(0));
        chk("bp_ts_ready", 128'(s_axis_ts_ready), 128'(0));
        chk("bp_evt_valid", 128'(m_axis_evt_valid), 128'(1));
        chk("bp_hold_seq", 128'(m_axis_evt_seq_id), 128'(16'h0001));
        @(posedge clk);
        rdy_mode = 1;
        @(negedge clk);
        chk("bp_pulse_ts_ready", 128'(s_axis_ts_ready), 128'(1));
        @(posedge clk);
        rdy_mode = 2;
        @(negedge clk);
        chk("bp_reload_valid", 128'(m_axis_evt_valid), 128'(1));
        chk("bp_reload_seq", 128'(m_axis_evt_seq_id), 128'(16'h0002));
        chk("bp_reload_match", 128'(stat_match), 128'(1));
        @(posedge clk); #1;
        rdy_mode = 1;
        wait_drain();

        // Early timestamp waits for the frame end
        ts = 96'hE0E1_E2E3_E4E5_E6E7_E8E9_EAEB;
        ts_q.push_back(ts);
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        chk("early_ts_valid", 128'(s_axis_ts_valid), 128'(1));
        chk("early_ts_ready", 128'(s_axis_ts_ready), 128'(0));
        @(posedge clk); #1;
        build(f, 64, 1'b0, 16'h88F7, 8'h02, 8'h02, 16'h5A5A);
        send_frame(f, 1'b0, ts, 1'b0);
        wait_drain();

        // VLAN-tagged Delay_Req
        m0 = obs_match; r0 = obs_reject;
        build(f, 64, 1'b1, 16'h88F7, 8'h01, 8'h02, 16'hBEEF);
        send_frame(f, 1'b0, 96'hC0FFEE, 1'b1);
        wait_drain();
`ifdef PTP_RX_VLAN_EN
        chk("vlan_match", 128'(obs_match - m0), 128'(1));
`else
        chk("vlan_reject", 128'(obs_reject - r0), 128'(1));
`endif

        // Reset mid-frame
        build(f, 64, 1'b0, 16'h88F7, 8'h00, 8'h02, 16'h7777);
        for (int i = 0; i <= 20; i++) drive_byte(f[i], 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_tready", 128'(s_axis_tready), 128'(0));
        chk("midrst_evt_valid", 128'(m_axis_evt_valid), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m0 = obs_match;
        build(f, 64, 1'b0, 16'h88F7, 8'h00, 8'h02, 16'h4321);
        send_frame(f, 1'b0, 96'hD00D, 1'b1);
        wait_drain();
        chk("midrst_one_record", 128'(obs_match - m0), 128'(1));
        chk("midrst_no_stale", 128'(m_axis_evt_valid), 128'(0));

        // Randomized frames
        gap_en = 1'b1;
        rdy_mode = 0;
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 7);
            len = $urandom_range(46, 90);
            tag = 1'b0; tuser = 1'b0; eth = 16'h88F7;
            b14 = {4'($urandom), 4'($urandom_range(0, 3))};
            b15 = {4'($urandom), 4'd2};
            seq = 16'($urandom);
            case (kind)
                2: eth = 16'($urandom);
                3: b14 = 8'($urandom);
                4: b15 = 8'($urandom);
                5: tuser = 1'b1;
                6: len = $urandom_range(30, 45);
                7: begin tag = 1'b1; len = $urandom_range(46, 90); end
                default: ;
            endcase
            build(f, len, tag, eth, b14, b15, seq);
            send_frame(f, tuser, {$urandom, $urandom, $urandom}, 1'b1);
        end
        rdy_mode = 1;
        wait_drain();
        chk("total_match", 128'(obs_match), 128'(exp_match));
        chk("total_reject", 128'(obs_reject), 128'(exp_reject));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
